// File: rtl/fifo_72x512_ctrl.sv
// 72-bit x 512-deep first-word-fall-through FIFO built on a 2-cycle registered-read block RAM.
// Define FIFO72_ALMOST_FULL_EN to add the registered almost_full output (threshold AF_THRESH).

module bram_72x512 (
    input  logic        clk,
    input  logic        we,
    input  logic [8:0]  wa,
    input  logic [71:0] wd,
    input  logic        re,
    input  logic [8:0]  ra,
    output logic [71:0] q
);
    logic [71:0] mem [512];
    logic [71:0] q_stage_reg;
    logic [71:0] q_reg;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wa] <= wd;
        end
        if (re) begin
            q_stage_reg <= mem[ra];
        end
        q_reg <= q_stage_reg;
    end

    assign q = q_reg;
endmodule

module fifo_72x512_ctrl #(
    parameter int AF_THRESH = 480
) (
    input  logic        c,
    input  logic        reset,
    input  logic [71:0] wd,
    input  logic        w,
    output logic        full,
    output logic [71:0] rd,
    output logic        valid,
    input  logic        r,
    output logic [9:0]  count,
    output logic        overflow,
    output logic        underflow
`ifdef FIFO72_ALMOST_FULL_EN
    ,
    output logic        almost_full
`endif
);
    localparam int DEPTH = 512;
    localparam int OB    = 3;

    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_af_thresh_invalid
        $error("AF_THRESH must lie in 1..512");
    end

    logic [8:0]  wp_reg;
    logic [8:0]  rp_reg;
    logic [9:0]  count_reg;
    logic [9:0]  ram_cnt_reg;
    logic        wr_vis_reg;
    logic [1:0]  pipe_reg;
    logic [1:0]  ob_cnt_reg;
    logic [71:0] ob_reg  [OB];
    logic [71:0] ob_next [OB];
    logic        overflow_reg;
    logic        underflow_reg;

    logic        wr_acc;
    logic        rd_acc;
    logic        issue;
    logic        push;
    logic [2:0]  slots_used;
    logic [1:0]  ob_wpos;
    logic [71:0] bram_q;

    assign full   = count_reg[9];
    assign valid  = (ob_cnt_reg != 2'd0);
    assign rd     = ob_reg[0];
    assign wr_acc = w & ~full & ~reset;
    assign rd_acc = r & valid;
    assign push   = pipe_reg[1];

    // A word being popped this cycle frees its slot, which keeps the read loop bubble-free.
    assign slots_used = {1'b0, ob_cnt_reg} + {2'b0, pipe_reg[0]} + {2'b0, pipe_reg[1]};
    assign issue      = (ram_cnt_reg != 10'd0) && (slots_used < (rd_acc ? 3'd4 : 3'd3));

    bram_72x512 u_bram (
        .clk (c),
        .we  (wr_acc),
        .wa  (wp_reg),
        .wd  (wd),
        .re  (issue),
        .ra  (rp_reg),
        .q   (bram_q)
    );

    // Output buffer is a shift register: head at entry 0, returning word lands after the last live entry.
    assign ob_wpos = ob_cnt_reg - {1'b0, rd_acc};

    for (genvar gi = 0; gi < OB; gi++) begin : g_ob
        logic [71:0] shifted;
        if (gi < OB - 1) begin : g_mid
            assign shifted = rd_acc ? ob_reg[gi+1] : ob_reg[gi];
        end else begin : g_last
            assign shifted = rd_acc ? 72'd0 : ob_reg[gi];
        end
        assign ob_next[gi] = (push && ob_wpos == 2'(gi)) ? bram_q : shifted;
    end

    always_ff @(posedge c) begin
        for (int i = 0; i < OB; i++) begin
            ob_reg[i] <= ob_next[i];
        end
    end

    // Written words become readable one cycle after the write, so a RAM read never
    // targets the slot being written and the end-to-end latency is four edges.
    always_ff @(posedge c) begin
        if (reset) begin
            wp_reg        <= '0;
            rp_reg        <= '0;
            count_reg     <= '0;
            ram_cnt_reg   <= '0;
            wr_vis_reg    <= 1'b0;
            pipe_reg      <= '0;
            ob_cnt_reg    <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (wr_acc) begin
                wp_reg <= wp_reg + 9'd1;
            end
            if (issue) begin
                rp_reg <= rp_reg + 9'd1;
            end
            count_reg   <= count_reg + {9'b0, wr_acc} - {9'b0, rd_acc};
            ram_cnt_reg <= ram_cnt_reg + {9'b0, wr_vis_reg} - {9'b0, issue};
            wr_vis_reg  <= wr_acc;
            pipe_reg    <= {pipe_reg[0], issue};
            ob_cnt_reg  <= ob_cnt_reg + {1'b0, push} - {1'b0, rd_acc};
            if (w && full) begin
                overflow_reg <= 1'b1;
            end
            if (r && !valid) begin
                underflow_reg <= 1'b1;
            end
        end
    end

    assign count     = count_reg;
    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;

`ifdef FIFO72_ALMOST_FULL_EN
    logic almost_full_reg;

    always_ff @(posedge c) begin
        if (reset) begin
            almost_full_reg <= 1'b0;
        end else begin
            almost_full_reg <= (count_reg >= 10'(AF_THRESH));
        end
    end

    assign almost_full = almost_full_reg;
`endif
endmodule
